// File: rtl/gb_input_pkg.sv
// Shared button indices, JOYP select-bit positions and nibble type for the joypad input block.
package gb_input_pkg;

   localparam int BTN_RIGHT  = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_UP     = 2;
   localparam int BTN_DOWN   = 3;
   localparam int BTN_A      = 4;
   localparam int BTN_B      = 5;
   localparam int BTN_SELECT = 6;
   localparam int BTN_START  = 7;

   // Positions within the CPU-written p1_sel pair (JOYP bits 4 and 5).
   localparam int JOYP_DIR_SEL = 0;
   localparam int JOYP_ACT_SEL = 1;

   typedef logic [3:0] joyp_nib_t;

endpackage

// File: rtl/gb_input_ctrl_if.sv
// Button/JOYP bundle between the board-facing side (master) and gb_input_ctrl (slave).
interface gb_input_ctrl_if #(
   parameter int unsigned NUM_CH = 8
);
   import gb_input_pkg::*;

   logic [NUM_CH-1:0] raw_btn;
   logic [1:0]        p1_sel;
   logic [NUM_CH-1:0] btn_state;
   logic [NUM_CH-1:0] press_evt;
   joyp_nib_t         p1_low;
   logic              joypad_irq;

   modport master (
      output raw_btn, p1_sel,
      input  btn_state, press_evt, p1_low, joypad_irq
   );

   modport slave (
      input  raw_btn, p1_sel,
      output btn_state, press_evt, p1_low, joypad_irq
   );

endinterface

// File: rtl/input_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced state and press pulse.
module input_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_n_i,
   output logic state_o,
   output logic press_o
);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             state_q, state_d;
   logic             press_q, press_d;
   logic             pressed_s;

   always_comb begin
      pressed_s = ~sync2_q;
      cnt_d     = cnt_q;
      state_d   = state_q;
      press_d   = 1'b0;
      if (pressed_s == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         // Terminal count clears the counter, so it can never wrap.
         state_d = pressed_s;
         cnt_d   = '0;
         press_d = pressed_s;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         state_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= raw_n_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         press_q <= press_d;
      end
   end

   assign state_o = state_q;
   assign press_o = press_q;

endmodule

// File: rtl/gb_input_ctrl.sv
// N-channel debounced button block driving JOYP low nibble and the joypad interrupt.
// Optional build macro GB_INPUT_SOCD_FILTER_EN masks opposing directions in the JOYP path.
module gb_input_ctrl
   import gb_input_pkg::*;
#(
   parameter int unsigned NUM_CH          = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input logic            clk,
   input logic            reset,
   gb_input_ctrl_if.slave joy_io
);

   logic [NUM_CH-1:0] btn_state;
   logic [NUM_CH-1:0] press_evt;
   joyp_nib_t         dir, act;
   joyp_nib_t         p1_low_q, p1_low_d;
   joyp_nib_t         p1_prev_q;
   logic              irq_q, irq_d;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      input_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk     (clk),
         .reset   (reset),
         .raw_n_i (joy_io.raw_btn[g]),
         .state_o (btn_state[g]),
         .press_o (press_evt[g])
      );
   end

   always_comb begin
      dir = btn_state[BTN_DOWN:BTN_RIGHT];
      act = btn_state[BTN_START:BTN_A];
`ifdef GB_INPUT_SOCD_FILTER_EN
      if (dir[BTN_LEFT] && dir[BTN_RIGHT]) begin
         dir[BTN_LEFT]  = 1'b0;
         dir[BTN_RIGHT] = 1'b0;
      end
      if (dir[BTN_UP] && dir[BTN_DOWN]) begin
         dir[BTN_UP]   = 1'b0;
         dir[BTN_DOWN] = 1'b0;
      end
`endif
      p1_low_d = ~(({4{~joy_io.p1_sel[JOYP_DIR_SEL]}} & dir) |
                   ({4{~joy_io.p1_sel[JOYP_ACT_SEL]}} & act));
      // Any 1->0 fall, including one exposed by a select change, requests the interrupt.
      irq_d = |(p1_prev_q & ~p1_low_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p1_low_q  <= 4'hF;
         p1_prev_q <= 4'hF;
         irq_q     <= 1'b0;
      end else begin
         p1_low_q  <= p1_low_d;
         p1_prev_q <= p1_low_q;
         irq_q     <= irq_d;
      end
   end

   assign joy_io.btn_state  = btn_state;
   assign joy_io.press_evt  = press_evt;
   assign joy_io.p1_low     = p1_low_q;
   assign joy_io.joypad_irq = irq_q;

endmodule

// File: tb/tb_gb_input_ctrl.sv
// Directed bench for gb_input_ctrl with DEBOUNCE_CYCLES=4; honours GB_INPUT_SOCD_FILTER_EN.
module tb_gb_input_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   gb_input_ctrl_if #(.NUM_CH(8)) joy ();

   gb_input_ctrl #(
      .NUM_CH          (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .joy_io (joy)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      reset       = 1'b1;
      joy.raw_btn = 8'hFF;
      joy.p1_sel  = 2'b11;
      step(3);
      chk("rst_btn_state", joy.btn_state, 8'h00);
      chk("rst_press_evt", joy.press_evt, 8'h00);
      chk("rst_p1_low", joy.p1_low, 4'hF);
      chk("rst_irq", joy.joypad_irq, 1'b0);
      reset = 1'b0;
      step(4);

      // Right pressed with directions selected
      joy.p1_sel = 2'b10;
      step(2);
      joy.raw_btn = 8'hFE;
      step(5);
      chk("right_edge5_state", joy.btn_state, 8'h00);
      step(1);
      chk("right_edge6_state", joy.btn_state, 8'h01);
      chk("right_edge6_evt", joy.press_evt, 8'h01);
      chk("right_edge6_p1", joy.p1_low, 4'hF);
      step(1);
      chk("right_edge7_p1", joy.p1_low, 4'hE);
      chk("right_edge7_evt", joy.press_evt, 8'h00);
      chk("right_edge7_irq", joy.joypad_irq, 1'b0);
      step(1);
      chk("right_edge8_irq", joy.joypad_irq, 1'b1);
      step(1);
      chk("right_edge9_irq", joy.joypad_irq, 1'b0);

      // Release: state falls, no event, no interrupt
      joy.raw_btn = 8'hFF;
      step(6);
      chk("rel_state", joy.btn_state, 8'h00);
      chk("rel_evt", joy.press_evt, 8'h00);
      step(1);
      chk("rel_p1", joy.p1_low, 4'hF);
      step(1);
      chk("rel_irq", joy.joypad_irq, 1'b0);
      step(2);

      // Three-cycle glitch on A is rejected
      joy.p1_sel = 2'b01;
      step(2);
      joy.raw_btn = 8'hEF;
      step(3);
      joy.raw_btn = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("glitch_state", joy.btn_state, 8'h00);
         chk("glitch_evt", joy.press_evt, 8'h00);
         chk("glitch_irq", joy.joypad_irq, 1'b0);
      end

      // A held while unselected, then exposed by select change
      joy.p1_sel  = 2'b10;
      joy.raw_btn = 8'hEF;
      step(6);
      chk("a_state", joy.btn_state, 8'h10);
      chk("a_evt", joy.press_evt, 8'h10);
      step(2);
      chk("a_hidden_p1", joy.p1_low, 4'hF);
      chk("a_hidden_irq", joy.joypad_irq, 1'b0);
      joy.p1_sel = 2'b01;
      step(1);
      chk("a_shown_p1", joy.p1_low, 4'hE);
      chk("a_shown_irq0", joy.joypad_irq, 1'b0);
      step(1);
      chk("a_shown_irq1", joy.joypad_irq, 1'b1);
      step(1);
      chk("a_shown_irq2", joy.joypad_irq, 1'b0);
      joy.raw_btn = 8'hFF;
      step(10);
      chk("a_rel_p1", joy.p1_low, 4'hF);

      // Right, Up and A together with both groups selected
      joy.p1_sel  = 2'b00;
      step(2);
      joy.raw_btn = 8'hEA;
      step(6);
      chk("multi_state", joy.btn_state, 8'h15);
      chk("multi_evt", joy.press_evt, 8'h15);
      step(1);
      chk("multi_p1", joy.p1_low, 4'hA);
      chk("multi_irq0", joy.joypad_irq, 1'b0);
      chk("multi_evt_clr", joy.press_evt, 8'h00);
      step(1);
      chk("multi_irq1", joy.joypad_irq, 1'b1);
      step(1);
      chk("multi_irq2", joy.joypad_irq, 1'b0);
      joy.raw_btn = 8'hFF;
      step(10);
      chk("multi_rel_state", joy.btn_state, 8'h00);

      // Reset at debounce count 2 of Start, button still held
      joy.raw_btn = 8'h7F;
      step(4);
      reset = 1'b1;
      step(2);
      chk("rst_mid_state", joy.btn_state, 8'h00);
      chk("rst_mid_p1", joy.p1_low, 4'hF);
      reset = 1'b0;
      step(5);
      chk("rst_rel_edge5", joy.btn_state, 8'h00);
      step(1);
      chk("rst_rel_edge6", joy.btn_state, 8'h80);
      chk("rst_rel_evt", joy.press_evt, 8'h80);
      step(1);
      chk("rst_rel_p1", joy.p1_low, 4'h7);
      joy.raw_btn = 8'hFF;
      step(10);

      // Left and Right together on the direction group
      joy.p1_sel  = 2'b10;
      joy.raw_btn = 8'hFC;
      step(7);
      chk("socd_state", joy.btn_state, 8'h03);
`ifdef GB_INPUT_SOCD_FILTER_EN
      chk("socd_p1", joy.p1_low, 4'hF);
`else
      chk("socd_p1", joy.p1_low, 4'hC);
`endif
      joy.raw_btn = 8'hFF;
      step(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gb_input_ctrl.md
Name: gb_input_ctrl

Overview:
- Parametrised, multi-channel button conditioning block for the Game Boy emulator top level.
- Takes raw, asynchronous, active-low board buttons. Synchronises and debounces each channel.
- Drives the Game Boy P1/JOYP (0xFF00) low-nibble lines from the CPU-written select bits, and raises the joypad interrupt request.
- Replaces direct KEY wiring with N debounced channels, per-channel press events and JOYP semantics.

Parameters:
- NUM_CH, 8, number of button channels. Must be >= 8. Channels 0..7 map to JOYP; channels 8+ only feed btn_state/press_evt.
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a change (1 ms at 50 MHz). Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width. Derived; do not override.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- raw_btn  in  NUM_CH  asynchronous raw buttons, active-low (0 = pressed).
- p1_sel  in  2  JOYP bits [5:4] as written by the CPU, active-low. bit0 = P14 selects directions; bit1 = P15 selects actions.
- btn_state  out  NUM_CH  debounced state, active-high (1 = pressed).
- press_evt  out  NUM_CH  one-cycle pulse when a channel's debounced state goes 0->1.
- p1_low  out  4  JOYP bits [3:0], active-low, registered.
- joypad_irq  out  1  one-cycle interrupt request pulse (IF bit 4).

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: sync flops = all 1s (released); btn_state = 0; counters = 0; press_evt = 0; p1_low = 4'hF; joypad_irq = 0.
- Reset asserted mid-debounce discards the partial count. A button still held after reset is re-detected after the full latency.
- Synchronisation: two-flop synchroniser per channel; sync_n = synchronised raw_btn. pressed_s = ~sync_n.
- Debounce, per channel:
  - If pressed_s == btn_state, the counter clears to 0.
  - Otherwise the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and the mismatch persists: btn_state <= pressed_s, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES clears the counter and produces no change.
  - The counter never wraps.
- Latency: a raw edge reaches btn_state after 2 + DEBOUNCE_CYCLES clk edges. press_evt asserts in the same cycle btn_state rises. Release produces no event.
- JOYP mapping:
  - Directions: ch0 Right, ch1 Left, ch2 Up, ch3 Down.
  - Actions: ch4 A, ch5 B, ch6 Select, ch7 Start.
  - p1_low[i] <= ~((~p1_sel[0] & dir[i]) | (~p1_sel[1] & act[i])), registered, one cycle after btn_state or p1_sel changes.
  - p1_sel = 2'b11 gives p1_low = 4'hF. p1_sel = 2'b00 ORs both groups.
- Interrupt:
  - joypad_irq = 1 for exactly one cycle when any p1_low bit goes 1->0, comparing against the previous registered p1_low.
  - A select-line change that exposes an already-held button also fires the IRQ (matches DMG hardware).
  - Simultaneous falls on several bits give a single pulse.
- Simultaneous events: independent channels may update in the same cycle; each gets its own press_evt.

Optional Feature:
- Macro: GB_INPUT_SOCD_FILTER_EN.
- Defined: in the JOYP path only, Left+Right both pressed masks both to released; Up+Down likewise. btn_state and press_evt are unaffected.
- Undefined: opposing directions pass through unchanged.

Decomposition:
- Package gb_input_pkg holds:
  - button index localparams (BTN_RIGHT=0 .. BTN_START=7),
  - JOYP_DIR_SEL/JOYP_ACT_SEL bit indices,
  - typedef joyp_nib_t (logic [3:0]).
- One sub-module, input_debounce: a single channel containing the synchroniser, counter, state and event. It is instantiated NUM_CH times via generate. JOYP/IRQ logic stays in gb_input_ctrl.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset with raw_btn=8'hFF -> btn_state=0, p1_low=4'hF, joypad_irq=0, press_evt=0.
- p1_sel=2'b10, raw_btn[0] held low from cycle 0 ->
  - btn_state[0]=1 and press_evt[0]=1 at edge 6,
  - p1_low=4'hE at edge 7,
  - joypad_irq=1 at edge 8 only.
- raw_btn[4] low for 3 cycles then high -> btn_state[4] stays 0, no press_evt, no IRQ.
- Hold A (ch4) with p1_sel=2'b10 -> p1_low=4'hF; then p1_sel=2'b01 -> p1_low=4'hE next cycle and one IRQ pulse.
- p1_sel=2'b00, Right and A debounced in the same cycle ->
  - p1_low=4'hE,
  - both press_evt bits pulse,
  - a single joypad_irq pulse.
- Assert reset at debounce count 2 of ch7, then release reset with the button still held -> btn_state[7]=0 through reset; rises 6 edges after reset deasserts. With GB_INPUT_SOCD_FILTER_EN, holding ch0+ch1 with p1_sel=2'b10 -> p1_low=4'hF.
